// File: rtl/frame_pattern_writer.sv
// rtl/frame_pattern_writer.sv - triggered, back-pressure-aware RGB565 test frame generator
module frame_pattern_writer #(
    parameter int H_DISP      = 800,
    parameter int V_DISP      = 480,
    parameter int BAR_W       = 100,
    parameter int CHECK_SHIFT = 5
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic        sdram_init_done,
    input  logic        start,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] fg_color,
    input  logic        wr_full,
    output logic        wr_en,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        frame_done
);

    localparam int              BW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [10:0]     X_LAST   = 11'(H_DISP - 1);
    localparam logic [10:0]     Y_LAST   = 11'(V_DISP - 1);
    localparam logic [BW-1:0]   BAR_LAST = BW'(BAR_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [10:0]   x;
    logic [10:0]   y;
    logic [10:0]   xy;
    logic [BW-1:0] bar_cnt;
    logic [2:0]    bar_idx;
    logic [1:0]    pat_q;
    logic [15:0]   fg_q;
    logic [15:0]   pix_data;
    logic [15:0]   bar_color;
    logic          last_pix;
    logic          launch;
    logic          issue;
    logic          wr_en_next;
    logic          busy_next;
    logic          frame_done_next;

    assign last_pix = (x == X_LAST) && (y == Y_LAST);
    assign xy       = x ^ y;

    // State register
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a start arriving while frame_done is still high is dropped
    // because the previous frame has not fully retired yet
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start && sdram_init_done && !frame_done) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!sdram_init_done) begin
                    state_next = S_IDLE;
                end else if (!wr_full && last_pix) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode: next values for the registered strobes
    always_comb begin
        launch          = (state == S_IDLE) && (state_next == S_WRITE);
        issue           = (state == S_WRITE) && sdram_init_done && !wr_full;
        wr_en_next      = issue;
        frame_done_next = (state == S_DONE);
        busy_next       = (state_next != S_IDLE) || frame_done_next;
    end

    // Colour-bar table lookup by current bar index
    always_comb begin
        case (bar_idx)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    end

    // Pixel value for the current (x, y) under the latched pattern
    always_comb begin
        case (pat_q)
            2'd0:    pix_data = fg_q;
            2'd1:    pix_data = bar_color;
            2'd2:    pix_data = xy[CHECK_SHIFT] ? fg_q : 16'h0000;
            default: pix_data = {x[9:5], x[9:4], x[9:5]};
        endcase
    end

    // Datapath: latch request, walk raster counters, register FIFO outputs
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_en      <= 1'b0;
            wr_data    <= 16'h0000;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            x          <= '0;
            y          <= '0;
            bar_cnt    <= '0;
            bar_idx    <= '0;
            pat_q      <= '0;
            fg_q       <= '0;
        end else begin
            wr_en      <= wr_en_next;
            busy       <= busy_next;
            frame_done <= frame_done_next;
            if (launch) begin
                pat_q   <= pattern_sel;
                fg_q    <= fg_color;
                x       <= '0;
                y       <= '0;
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (issue) begin
                wr_data <= pix_data;
                if (x == X_LAST) begin
                    x       <= '0;
                    y       <= y + 11'd1;
                    bar_cnt <= '0;
                    bar_idx <= '0;
                end else begin
                    x <= x + 11'd1;
                    if (bar_cnt == BAR_LAST) begin
                        bar_cnt <= '0;
                        if (bar_idx != 3'd7) begin
                            bar_idx <= bar_idx + 3'd1;
                        end
                    end else begin
                        bar_cnt <= bar_cnt + BW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_pattern_writer.sv
// tb/tb_frame_pattern_writer.sv - self-checking bench for frame_pattern_writer
module tb_frame_pattern_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sdram_init_done;
    logic        start;
    logic [1:0]  pattern_sel;
    logic [15:0] fg_color;
    logic        wr_full;

    logic        a_wr_en, b_wr_en, c_wr_en, d_wr_en;
    logic [15:0] a_wr_data, b_wr_data, c_wr_data, d_wr_data;
    logic        a_busy, b_busy, c_busy, d_busy;
    logic        a_frame_done, b_frame_done, c_frame_done, d_frame_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [15:0] a_q[$], b_q[$], c_q[$], d_q[$];
    int          a_t[$];
    int          a_done_cnt = 0;
    int          a_done_cyc = 0;

    // model state for dut_a (8x4, BAR_W=2, CHECK_SHIFT=1)
    logic        m_run, m_tail;
    int          m_n;
    logic [1:0]  m_pat;
    logic [15:0] m_fg;
    logic        exp_wr_en, exp_busy, exp_done;
    logic [15:0] exp_data;

    always #5 clk = ~clk;

    frame_pattern_writer #(.H_DISP(8), .V_DISP(4), .BAR_W(2), .CHECK_SHIFT(1)) dut_a (
        .clk_50m(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done), .start(start),
        .pattern_sel(pattern_sel), .fg_color(fg_color), .wr_full(wr_full),
        .wr_en(a_wr_en), .wr_data(a_wr_data), .busy(a_busy), .frame_done(a_frame_done));

    frame_pattern_writer #(.H_DISP(16), .V_DISP(1), .BAR_W(2), .CHECK_SHIFT(5)) dut_b (
        .clk_50m(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done), .start(start),
        .pattern_sel(pattern_sel), .fg_color(fg_color), .wr_full(wr_full),
        .wr_en(b_wr_en), .wr_data(b_wr_data), .busy(b_busy), .frame_done(b_frame_done));

    frame_pattern_writer #(.H_DISP(4), .V_DISP(4), .BAR_W(1), .CHECK_SHIFT(1)) dut_c (
        .clk_50m(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done), .start(start),
        .pattern_sel(pattern_sel), .fg_color(fg_color), .wr_full(wr_full),
        .wr_en(c_wr_en), .wr_data(c_wr_data), .busy(c_busy), .frame_done(c_frame_done));

    frame_pattern_writer #(.H_DISP(64), .V_DISP(1), .BAR_W(5), .CHECK_SHIFT(5)) dut_d (
        .clk_50m(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done), .start(start),
        .pattern_sel(pattern_sel), .fg_color(fg_color), .wr_full(wr_full),
        .wr_en(d_wr_en), .wr_data(d_wr_data), .busy(d_busy), .frame_done(d_frame_done));

    function automatic logic [15:0] bar_rgb(int b);
        case (b)
            0:       return 16'hFFFF;
            1:       return 16'hFFE0;
            2:       return 16'h07FF;
            3:       return 16'h07E0;
            4:       return 16'hF81F;
            5:       return 16'hF800;
            6:       return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // pixel n of a raster frame, computed directly from its coordinates
    function automatic logic [15:0] pix(int h, int bw, int cs, logic [1:0] p, logic [15:0] fg, int n);
        int x, y, b, v;
        logic [10:0] xv;
        logic [10:0] t;
        x  = n % h;
        y  = n / h;
        v  = x;
        xv = v[10:0];
        v  = x ^ y;
        t  = v[10:0];
        case (p)
            2'd0: return fg;
            2'd1: begin
                b = x / bw;
                if (b > 7) b = 7;
                return bar_rgb(b);
            end
            2'd2:    return t[cs] ? fg : 16'h0000;
            default: return {xv[9:5], xv[9:4], xv[9:5]};
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_frame(string nm, input logic [15:0] q[$], input int h, input int bw,
                               input int cs, input int total, input logic [1:0] p, input logic [15:0] fg);
        chk({nm, " count"}, q.size(), total);
        for (int i = 0; i < q.size() && i < total; i++)
            chk($sformatf("%s px%0d", nm, i), {16'h0, q[i]}, {16'h0, pix(h, bw, cs, p, fg, i)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        a_q.delete(); b_q.delete(); c_q.delete(); d_q.delete(); a_t.delete();
        a_done_cnt = 0;
        a_done_cyc = 0;
    endtask

    task automatic start_frame(logic [1:0] p, logic [15:0] fg);
        pattern_sel = p;
        fg_color    = fg;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        pattern_sel = ~p;
        fg_color    = ~fg;
    endtask

    task automatic wait_idle(string nm);
        int n = 0;
        while ((a_busy || b_busy || c_busy || d_busy) && n < 1000) begin
            tick();
            n++;
        end
        chk({nm, " idle timeout"}, (n >= 1000) ? 1 : 0, 0);
        repeat (2) tick();
    endtask

    // returns in the cycle in which dut_a presents its k-th write
    task automatic wait_write(string nm, int k);
        int n = 0;
        while (!(a_wr_en && a_q.size() == k - 1) && n < 500) begin
            tick();
            n++;
        end
        chk({nm, " write timeout"}, (n >= 500) ? 1 : 0, 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // capture every write of each instance
    always @(negedge clk) begin
        if (a_wr_en) begin a_q.push_back(a_wr_data); a_t.push_back(cyc); end
        if (b_wr_en) b_q.push_back(b_wr_data);
        if (c_wr_en) c_q.push_back(c_wr_data);
        if (d_wr_en) d_q.push_back(d_wr_data);
        if (a_frame_done) begin a_done_cnt++; a_done_cyc = cyc; end
    end

    // behavioural model of dut_a in terms of pixels issued
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0; m_tail <= 1'b0; m_n <= 0; m_pat <= 2'd0; m_fg <= 16'h0;
            exp_wr_en <= 1'b0; exp_data <= 16'h0; exp_busy <= 1'b0; exp_done <= 1'b0;
        end else begin
            exp_wr_en <= 1'b0;
            exp_done  <= 1'b0;
            if (m_run) begin
                if (!sdram_init_done) begin
                    m_run    <= 1'b0;
                    exp_busy <= 1'b0;
                end else if (!wr_full) begin
                    exp_wr_en <= 1'b1;
                    exp_data  <= pix(8, 2, 1, m_pat, m_fg, m_n);
                    m_n       <= m_n + 1;
                    if (m_n == 31) begin
                        m_run  <= 1'b0;
                        m_tail <= 1'b1;
                    end
                end
            end else if (m_tail) begin
                m_tail   <= 1'b0;
                exp_done <= 1'b1;
            end else if (exp_done) begin
                exp_busy <= 1'b0;
            end else if (start && sdram_init_done) begin
                m_run    <= 1'b1;
                m_n      <= 0;
                m_pat    <= pattern_sel;
                m_fg     <= fg_color;
                exp_busy <= 1'b1;
            end
        end
    end

    // cycle-by-cycle compare of dut_a against the model
    always @(negedge clk) begin
        chk("a wr_en", {31'h0, a_wr_en}, {31'h0, exp_wr_en});
        chk("a busy", {31'h0, a_busy}, {31'h0, exp_busy});
        chk("a frame_done", {31'h0, a_frame_done}, {31'h0, exp_done});
        if (exp_wr_en) chk("a wr_data", {16'h0, a_wr_data}, {16'h0, exp_data});
    end

    logic [15:0] bars16 [16];
    logic [15:0] chk_row[4];

    initial begin
        bars16 = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hFFE0, 16'h07FF, 16'h07FF, 16'h07E0, 16'h07E0,
                   16'hF81F, 16'hF81F, 16'hF800, 16'hF800, 16'h001F, 16'h001F, 16'h0000, 16'h0000};
        chk_row = '{16'h0000, 16'h0000, 16'h07E0, 16'h07E0};
        rst_n = 1'b0; sdram_init_done = 1'b0; start = 1'b0;
        pattern_sel = 2'd0; fg_color = 16'h0; wr_full = 1'b0;
        repeat (3) tick();
        chk("reset b outputs", {b_wr_en, b_busy, b_frame_done, b_wr_data}, 19'h0);
        chk("reset d outputs", {d_wr_en, d_busy, d_frame_done, d_wr_data}, 19'h0);
        rst_n = 1'b1;
        sdram_init_done = 1'b1;
        tick();

        // solid frame
        clr();
        start_frame(2'd0, 16'hF800);
        wait_idle("solid");
        check_frame("solid", a_q, 8, 2, 1, 32, 2'd0, 16'hF800);
        if (a_q.size() == 32) chk("solid literal px31", {16'h0, a_q[31]}, 32'hF800);
        if (a_t.size() == 32) begin
            chk("solid contiguous", a_t[31] - a_t[0], 31);
            chk("solid done timing", a_done_cyc, a_t[31] + 1);
        end
        chk("solid done count", a_done_cnt, 1);

        // colour bars
        clr();
        start_frame(2'd1, 16'h1234);
        wait_idle("bars");
        chk("bars16 count", b_q.size(), 16);
        for (int i = 0; i < 16 && i < b_q.size(); i++)
            chk($sformatf("bars16 px%0d", i), {16'h0, b_q[i]}, {16'h0, bars16[i]});
        check_frame("bars8x4", a_q, 8, 2, 1, 32, 2'd1, 16'h1234);
        check_frame("bars64", d_q, 64, 5, 5, 64, 2'd1, 16'h1234);
        if (d_q.size() == 64) begin
            chk("bars64 px34", {16'h0, d_q[34]}, 32'h001F);
            chk("bars64 px40 saturated", {16'h0, d_q[40]}, 32'h0000);
        end

        // gradient with a 5-cycle stall after the 10th write
        clr();
        start_frame(2'd3, 16'h0);
        wait_write("stall", 10);
        wr_full = 1'b1;
        repeat (5) tick();
        wr_full = 1'b0;
        wait_idle("stall");
        check_frame("grad8x4", a_q, 8, 2, 1, 32, 2'd3, 16'h0);
        if (a_t.size() == 32) begin
            chk("stall gap", a_t[10] - a_t[9], 6);
            chk("stall span", a_t[31] - a_t[0], 36);
        end
        check_frame("grad64", d_q, 64, 5, 5, 64, 2'd3, 16'h0);
        if (d_q.size() == 64) begin
            chk("grad64 px16", {16'h0, d_q[16]}, 32'h0020);
            chk("grad64 px32", {16'h0, d_q[32]}, 32'h0841);
            chk("grad64 px48", {16'h0, d_q[48]}, 32'h0861);
        end

        // bars under irregular back-pressure
        clr();
        start_frame(2'd1, 16'h0);
        for (int n = 0; n < 500 && a_busy; n++) begin
            wr_full = ((n % 4) == 2) || ((n % 7) == 3);
            tick();
        end
        wr_full = 1'b0;
        wait_idle("toggle");
        check_frame("toggle", a_q, 8, 2, 1, 32, 2'd1, 16'h0);

        // ignored starts: with init low, during WRITE, and on frame_done
        clr();
        sdram_init_done = 1'b0;
        start_frame(2'd0, 16'hAAAA);
        repeat (4) tick();
        chk("init-low start writes", a_q.size(), 0);
        chk("init-low start busy", {31'h0, a_busy}, 0);
        sdram_init_done = 1'b1;
        tick();
        start_frame(2'd0, 16'h001F);
        wait_write("mid start", 3);
        start_frame(2'd2, 16'hFFFF);
        for (int n = 0; n < 200 && !a_frame_done; n++) tick();
        chk("frame_done seen", {31'h0, a_frame_done}, 1);
        start_frame(2'd2, 16'hFFFF);
        wait_idle("ignored");
        check_frame("ignored", a_q, 8, 2, 1, 32, 2'd0, 16'h001F);
        chk("ignored done count", a_done_cnt, 1);

        // checkerboard
        clr();
        start_frame(2'd2, 16'h07E0);
        wait_idle("checker");
        chk("checker count", c_q.size(), 16);
        for (int i = 0; i < 16 && i < c_q.size(); i++)
            chk($sformatf("checker px%0d", i), {16'h0, c_q[i]},
                {16'h0, ((i / 8) == 0) ? chk_row[i % 4] : (chk_row[i % 4] ^ 16'h07E0)});
        check_frame("checker8x4", a_q, 8, 2, 1, 32, 2'd2, 16'h07E0);

        // abort by dropping init_done at the 5th write
        clr();
        start_frame(2'd1, 16'h0);
        wait_write("abort init", 5);
        sdram_init_done = 1'b0;
        tick();
        chk("abort init wr_en", {31'h0, a_wr_en}, 0);
        chk("abort init busy", {31'h0, a_busy}, 0);
        repeat (3) tick();
        sdram_init_done = 1'b1;
        repeat (3) tick();
        chk("abort init no done", a_done_cnt, 0);
        chk("abort init writes", a_q.size(), 5);
        clr();
        start_frame(2'd1, 16'h0);
        wait_idle("after abort");
        check_frame("after abort", a_q, 8, 2, 1, 32, 2'd1, 16'h0);

        // abort by reset at the 12th write
        clr();
        start_frame(2'd3, 16'h0);
        wait_write("abort rst", 12);
        rst_n = 1'b0;
        #1;
        chk("reset wr_en", {31'h0, a_wr_en}, 0);
        chk("reset busy", {31'h0, a_busy}, 0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("reset no done", a_done_cnt, 0);
        clr();
        start_frame(2'd1, 16'h0);
        wait_idle("after reset");
        check_frame("after reset", a_q, 8, 2, 1, 32, 2'd1, 16'h0);
        chk("after reset done count", a_done_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
